uart_apb_ctrl: RTL and testbench

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

---
 rtl/uart_apb_ctrl_if.sv | 27 ++
 rtl/uart_apb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_ctrl_if.sv
// APB slave bus bundle for uart_apb_ctrl.
// Latency: none (wires only).
// Backpressure: none; the slave is zero-wait, so pready_o is tied high.
//
// Signals: psel_i/penable_i/pwrite_i control, paddr_i address, pwdata_i write data,
//          prdata_o read data, pready_o ready, pslverr_o error.
//          The slave modport is used by the controller; the master modport drives the bus.
interface uart_apb_ctrl_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/uart_apb_ctrl.sv
// UART register block: APB slave with CTRL/BAUD/TXDATA/RXDATA/STATUS/ERR, TX and RX FIFOs, irq.
// Latency: APB zero-wait with combinational read data; tx valid and irq are registered (1 cycle).
// Backpressure: TX holds valid/data until tready; RX deasserts tready while its FIFO is full.
//
// Ports: clk_i/rst_i clock and async active-high reset; apb bus bundle (slave modport);
//        tx_axis_* byte stream to uart_tx; rx_axis_* byte stream from uart_rx;
//        parity_err_i/stop_err_i error pulses; baudrate_o divisor; irq_o level interrupt.
module uart_apb_ctrl #(
  parameter int          DATA_WIDTH = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [16:0] BAUD_RST   = 17'd868
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  uart_apb_ctrl_if.slave        apb,
  output logic [DATA_WIDTH-1:0] tx_axis_tdata_o,
  output logic                  tx_axis_tvalid_o,
  input  logic                  tx_axis_tready_i,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata_i,
  input  logic                  rx_axis_tvalid_i,
  output logic                  rx_axis_tready_o,
  input  logic                  parity_err_i,
  input  logic                  stop_err_i,
  output logic [16:0]           baudrate_o,
  output logic                  irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_BAUD   = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_ERR    = 3'd5;

  // ---------------------------------------------------------------- state
  logic [4:0]            ctrl_q;   // {err_ie, tx_ie, rx_ie, rx_en, tx_en}
  logic [16:0]           baud_q;
  logic [2:0]            err_q;    // {tx_ovf, stop_err, parity_err}
  logic                  tx_vld_q;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]         tx_count;
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]         rx_count;

  // ---------------------------------------------------------------- decode
  logic [2:0] reg_idx;
  logic       access, addr_ok, wr_ok, rd_ok;

  assign reg_idx = apb.paddr_i[4:2];
  assign addr_ok = (apb.paddr_i[31:5] == 27'd0) && (reg_idx <= A_ERR);
  assign access  = apb.psel_i & apb.penable_i & ~rst_i;
  assign wr_ok   = access & addr_ok & apb.pwrite_i;
  assign rd_ok   = access & addr_ok & ~apb.pwrite_i;

  // Byte lanes below bit 2 and write data above the widest register are don't-care.
  logic unused_apb;
  assign unused_apb = ^{apb.paddr_i[1:0], apb.pwdata_i[31:17]};

  // ---------------------------------------------------------------- FIFO status
  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);

  // TX: fullness is sampled before the edge, so a write while full is dropped
  // even if the stream side pops in the same cycle.
  logic          tx_push_req, tx_push, tx_pop, tx_ovf;
  logic [CW-1:0] tx_count_nxt;
  assign tx_push_req  = wr_ok & (reg_idx == A_TXDATA);
  assign tx_push      = tx_push_req & ~tx_full;
  assign tx_ovf       = tx_push_req & tx_full;
  assign tx_pop       = tx_vld_q & tx_axis_tready_i;
  assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);

  logic rx_push, rx_pop;
  assign rx_axis_tready_o = ctrl_q[1] & ~rx_full;
  assign rx_push          = rx_axis_tvalid_i & rx_axis_tready_o;
  assign rx_pop           = rd_ok & (reg_idx == A_RXDATA) & ~rx_empty;

  // Set events take priority over the W1C clear landing on the same edge.
  logic [2:0] err_set, err_clr;
  assign err_set = {tx_ovf, stop_err_i, parity_err_i};
  assign err_clr = (wr_ok && reg_idx == A_ERR) ? apb.pwdata_i[2:0] : 3'b000;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      baud_q <= BAUD_RST;
      err_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ok && reg_idx == A_CTRL)
        ctrl_q <= apb.pwdata_i[4:0];
      if (wr_ok && reg_idx == A_BAUD && apb.pwdata_i[16:0] != 17'd0)
        baud_q <= apb.pwdata_i[16:0];
      err_q <= (err_q & ~err_clr) | err_set;
      irq_q <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty) | (ctrl_q[4] & (|err_q));
    end
  end

  // Valid only re-evaluates when the output slot is free, which keeps valid and
  // the FIFO head frozen while a transfer waits; clearing tx_en stops only new ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      tx_vld_q <= 1'b0;
    else if (!tx_vld_q || tx_axis_tready_i)
      tx_vld_q <= ctrl_q[0] && (tx_count_nxt != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count_nxt;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= apb.pwdata_i[DATA_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_axis_tdata_i;
  end

  // ---------------------------------------------------------------- read mux
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (reg_idx)
      A_CTRL:   rdata = {27'd0, ctrl_q};
      A_BAUD:   rdata = {15'd0, baud_q};
      A_RXDATA: rdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr]);
      A_STATUS: rdata = {12'd0, 4'(rx_count), 4'd0, 4'(tx_count), 4'd0,
                         rx_full, rx_empty, tx_full, tx_empty};
      A_ERR:    rdata = {29'd0, err_q};
      default:  rdata = '0;
    endcase
  end

  assign apb.prdata_o  = rd_ok ? rdata : 32'd0;
  assign apb.pready_o  = 1'b1;
  assign apb.pslverr_o = access & ~addr_ok;

  assign tx_axis_tdata_o  = tx_mem[tx_rd_ptr];
  assign tx_axis_tvalid_o = tx_vld_q;
  assign baudrate_o       = baud_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed bench for uart_apb_ctrl: reset, BAUD, TX FIFO/stream, RX FIFO/stream, ERR/irq, reset mid-transfer.
// Latency: stimulus on negedge, sampling 1 time unit after it.
// Backpressure: tready/tvalid of the streams are driven directly by the sequence.
module tb_uart_apb_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_tdata, rx_tdata;
  logic       tx_tvalid, tx_tready, rx_tvalid, rx_tready;
  logic       parity_err, stop_err, irq;
  logic [16:0] baud;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        err;

  uart_apb_ctrl_if apb ();

  uart_apb_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BAUD_RST(17'd868)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .apb              (apb.slave),
    .tx_axis_tdata_o  (tx_tdata),
    .tx_axis_tvalid_o (tx_tvalid),
    .tx_axis_tready_i (tx_tready),
    .rx_axis_tdata_i  (rx_tdata),
    .rx_axis_tvalid_i (rx_tvalid),
    .rx_axis_tready_o (rx_tready),
    .parity_err_i     (parity_err),
    .stop_err_i       (stop_err),
    .baudrate_o       (baud),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup phase, access phase (sampled #1 after negedge), idle.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic serr);
    @(negedge clk);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
    apb.paddr_i = a;   apb.pwdata_i = d;
    @(negedge clk);
    apb.penable_i = 1'b1;
    #1;
    rdat = apb.prdata_o;
    serr = apb.pslverr_o;
    @(negedge clk);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    apb_xfer(1'b1, a, d, r, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    apb_xfer(1'b0, a, 32'd0, r, e);
    check(tag, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx_exp [4];
    tx_exp[0] = 8'h11; tx_exp[1] = 8'h22; tx_exp[2] = 8'h33; tx_exp[3] = 8'h44;

    rst = 1'b1;
    tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0;
    parity_err = 1'b0; stop_err = 1'b0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = '0; apb.pwdata_i = '0;

    // ---- reset state, including an access attempted while in reset
    @(negedge clk);
    @(negedge clk);
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.paddr_i = 32'h18;
    #1;
    check("rst_pslverr", {31'd0, apb.pslverr_o}, 32'd0);
    check("rst_pready",  {31'd0, apb.pready_o},  32'd1);
    apb.paddr_i = 32'h4;
    #1;
    check("rst_prdata", apb.prdata_o, 32'd0);
    check("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("rst_rx_tready", {31'd0, rx_tready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_baud", {15'd0, baud}, 32'd868);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    rd_chk("ctrl_reset", 32'h00, 32'd0);
    rd_chk("status_reset", 32'h10, 32'h0000_0005);

    // ---- BAUD: zero write ignored
    apb_wr(32'h04, 32'h1B2);
    apb_wr(32'h04, 32'h0);
    rd_chk("baud_read", 32'h04, 32'h1B2);
    check("baudrate_o", {15'd0, baud}, 32'h1B2);

    // ---- TX: fill with tx disabled, overflow on the 5th write
    apb_wr(32'h08, 32'h11);
    apb_wr(32'h08, 32'h22);
    apb_wr(32'h08, 32'h33);
    apb_wr(32'h08, 32'h44);
    apb_wr(32'h08, 32'h55);
    rd_chk("status_tx_full", 32'h10, 32'h0000_0406);
    rd_chk("err_tx_ovf", 32'h14, 32'h4);
    check("tx_idle_while_disabled", {31'd0, tx_tvalid}, 32'd0);
    tx_tready = 1'b1;
    apb_wr(32'h00, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("tx_stream_vld", {31'd0, tx_tvalid}, 32'd1);
      check("tx_stream_dat", {24'd0, tx_tdata}, {24'd0, tx_exp[i]});
    end
    @(negedge clk);
    #1;
    check("tx_drained_vld", {31'd0, tx_tvalid}, 32'd0);
    tx_tready = 1'b0;
    apb_wr(32'h14, 32'h4);
    rd_chk("err_w1c", 32'h14, 32'h0);

    // ---- TX hold: valid and data stable under backpressure and tx_en clear
    apb_wr(32'h08, 32'hA1);
    apb_wr(32'h08, 32'hA2);
    #1;
    check("hold_vld", {31'd0, tx_tvalid}, 32'd1);
    check("hold_dat", {24'd0, tx_tdata}, 32'hA1);
    apb_wr(32'h00, 32'h0);
    @(negedge clk);
    #1;
    check("hold_vld_txen0", {31'd0, tx_tvalid}, 32'd1);
    check("hold_dat_txen0", {24'd0, tx_tdata}, 32'hA1);
    tx_tready = 1'b1;
    @(negedge clk);
    tx_tready = 1'b0;
    #1;
    check("one_byte_vld_drop", {31'd0, tx_tvalid}, 32'd0);
    rd_chk("status_tx_one_left", 32'h10, 32'h0000_0104);

    // ---- RX: 4 accepted, 5th stalls until an RXDATA pop frees a slot
    apb_wr(32'h00, 32'h2);
    #1;
    check("rx_tready_en", {31'd0, rx_tready}, 32'd1);
    rx_tvalid = 1'b1; rx_tdata = 8'h61;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      rx_tdata = 8'h61 + 8'(k);
    end
    @(negedge clk);
    rx_tdata = 8'h65;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0; apb.paddr_i = 32'h0C;
    #1;
    check("rx_full_tready", {31'd0, rx_tready}, 32'd0);
    @(negedge clk);
    apb.penable_i = 1'b1;
    #1;
    check("rx_pop_same_cycle", apb.prdata_o, 32'h61);
    check("rx_tready_still0", {31'd0, rx_tready}, 32'd0);
    @(negedge clk);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    #1;
    check("rx_tready_after_pop", {31'd0, rx_tready}, 32'd1);
    @(negedge clk);
    rx_tvalid = 1'b0;
    rd_chk("status_rx_count4", 32'h10, 32'h0004_0108);
    rd_chk("rx_head0", 32'h0C, 32'h62);
    rd_chk("rx_head1", 32'h0C, 32'h63);
    rd_chk("rx_head2", 32'h0C, 32'h64);
    rd_chk("rx_head3", 32'h0C, 32'h65);
    rd_chk("rx_empty_read", 32'h0C, 32'h0);
    rd_chk("status_rx_empty", 32'h10, 32'h0000_0104);

    // ---- ERR: parity set wins over a same-cycle W1C, irq one cycle later
    apb_wr(32'h00, 32'h10);
    check("irq_err_ie_idle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 32'h14; apb.pwdata_i = 32'h1;
    @(negedge clk);
    apb.penable_i = 1'b1;
    parity_err = 1'b1;
    @(negedge clk);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    parity_err = 1'b0;
    #1;
    check("irq_latency_0", {31'd0, irq}, 32'd0);
    @(negedge clk);
    #1;
    check("irq_latency_1", {31'd0, irq}, 32'd1);
    rd_chk("err_parity_sticky", 32'h14, 32'h1);
    stop_err = 1'b1;
    @(negedge clk);
    stop_err = 1'b0;
    rd_chk("err_stop", 32'h14, 32'h3);
    apb_wr(32'h14, 32'h3);
    #1;
    check("irq_still_high", {31'd0, irq}, 32'd1);
    @(negedge clk);
    #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("err_cleared", 32'h14, 32'h0);

    // ---- reset while a TX transfer waits for tready
    apb_wr(32'h00, 32'h1);
    @(negedge clk);
    #1;
    check("wait_vld", {31'd0, tx_tvalid}, 32'd1);
    check("wait_dat", {24'd0, tx_tdata}, 32'hA2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_vld", {31'd0, tx_tvalid}, 32'd0);
    check("midrst_baud", {15'd0, baud}, 32'd868);
    check("midrst_rx_tready", {31'd0, rx_tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("status_after_rst", 32'h10, 32'h0000_0005);

    // ---- decode errors and RO/WO behaviour
    apb_xfer(1'b0, 32'h18, 32'd0, rd, err);
    check("unmapped_18_err", {31'd0, err}, 32'd1);
    check("unmapped_18_data", rd, 32'd0);
    apb_xfer(1'b1, 32'h24, 32'h55, rd, err);
    check("high_addr_err", {31'd0, err}, 32'd1);
    rd_chk("baud_untouched", 32'h04, 32'd868);
    apb_xfer(1'b0, 32'h08, 32'd0, rd, err);
    check("txdata_read_data", rd, 32'd0);
    check("txdata_read_err", {31'd0, err}, 32'd0);
    apb_xfer(1'b1, 32'h10, 32'hFFFF_FFFF, rd, err);
    check("status_write_err", {31'd0, err}, 32'd0);
    rd_chk("status_unchanged", 32'h10, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
